// File: rtl/vcve2_pkg.sv
// -----------------------------------------------------------------------------
// vcve2_pkg
// Shared types and constants for the VCVE2 data-memory arbiter.
//   arb_src_e   : requester identity, stored in the response-ID FIFO.
//   arb_state_t : arbiter FSM state vector; states are plain localparams.
// Helper functions map a source to its peer and to its hold state.
// -----------------------------------------------------------------------------
package vcve2_pkg;

    typedef enum logic {
        ARB_SRC_VRF = 1'b0,
        ARB_SRC_LSU = 1'b1
    } arb_src_e;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE     = 2'd0;
    localparam arb_state_t ARB_HOLD_VRF = 2'd1;
    localparam arb_state_t ARB_HOLD_LSU = 2'd2;

    function automatic arb_src_e arb_other(input arb_src_e src);
        return (src == ARB_SRC_VRF) ? ARB_SRC_LSU : ARB_SRC_VRF;
    endfunction

    function automatic arb_state_t arb_hold_state(input arb_src_e src);
        return (src == ARB_SRC_VRF) ? ARB_HOLD_VRF : ARB_HOLD_LSU;
    endfunction

endpackage

// File: rtl/vcve2_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// vcve2_arb_id_fifo
// Circular FIFO of requester IDs, one entry per granted, not yet answered
// memory transaction. The head names the requester owning the next response.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push_i, push_src_i   : enqueue an ID (accepted when not full, or when a pop
//                          happens in the same cycle)
//   pop_i                : dequeue the head (ignored when empty)
//   full_o, empty_o      : occupancy status
//   head_o               : ID at the head of the queue
// Parameter Depth (>= 1) sets the number of entries.
// -----------------------------------------------------------------------------
module vcve2_arb_id_fifo
    import vcve2_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  arb_src_e push_src_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output arb_src_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    arb_src_e        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs, even at Depth 1.
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, because cnt_q gates every pop.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_src_i;
    end

endmodule

// File: rtl/vcve2_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// vcve2_dmem_arbiter
// Shares one data-memory port between the vector register file (vrf) and the
// load/store unit (lsu). An idle arbiter selects a requester combinationally;
// an ungranted request is held until granted. Response routing follows the
// order of grants, tracked in an ID FIFO of depth MaxOutstanding.
// Ports:
//   clk_i, rst_ni                        : clock, asynchronous active-low reset
//   {vrf,lsu}_req/we/be/addr/wdata_i     : requester command
//   {vrf,lsu}_gnt/rvalid/rdata/err_o     : requester grant and response
//   data_req/we/be/addr/wdata_o          : memory command
//   data_gnt/rvalid/err/rdata_i          : memory grant and response
//   busy_o                               : transactions in flight or pending
//   spurious_rvalid_o                    : sticky, rvalid seen with none in flight
// Build option: define VCVE2_ARB_RR_EN for round-robin tie breaking; otherwise
// VRF has fixed priority over LSU.
// -----------------------------------------------------------------------------
module vcve2_dmem_arbiter
    import vcve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 vrf_req_i,
    input  logic                 vrf_we_i,
    input  logic [3:0]           vrf_be_i,
    input  logic [AddrWidth-1:0] vrf_addr_i,
    input  logic [31:0]          vrf_wdata_i,
    output logic                 vrf_gnt_o,
    output logic                 vrf_rvalid_o,
    output logic [31:0]          vrf_rdata_o,
    output logic                 vrf_err_o,

    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic [3:0]           lsu_be_i,
    input  logic [AddrWidth-1:0] lsu_addr_i,
    input  logic [31:0]          lsu_wdata_i,
    output logic                 lsu_gnt_o,
    output logic                 lsu_rvalid_o,
    output logic [31:0]          lsu_rdata_o,
    output logic                 lsu_err_o,

    output logic                 data_req_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [AddrWidth-1:0] data_addr_o,
    output logic [31:0]          data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    input  logic [31:0]          data_rdata_i,

    output logic                 busy_o,
    output logic                 spurious_rvalid_o
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic                 held;
    arb_src_e             tie_sel;
    arb_src_e             idle_sel;
    arb_src_e             sel;
    logic                 sel_valid;
    logic                 slot_free;
    logic                 grant;
    logic                 pop;

    logic                 hold_we_q;
    logic [3:0]           hold_be_q;
    logic [AddrWidth-1:0] hold_addr_q;
    logic [31:0]          hold_wdata_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    arb_src_e             fifo_head;

    // ------------------------------------------------------------------
    // Tie breaking between simultaneous requests in ARB_IDLE
    // ------------------------------------------------------------------
`ifdef VCVE2_ARB_RR_EN
    // Points at the source that wins the next tie: the one not granted last.
    arb_src_e rr_prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_prio_q <= ARB_SRC_VRF;
        end else if (grant) begin
            rr_prio_q <= arb_other(sel);
        end
    end

    assign tie_sel = rr_prio_q;
`else
    assign tie_sel = ARB_SRC_VRF;
`endif

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        idle_sel = ARB_SRC_VRF;
        if (vrf_req_i && lsu_req_i) begin
            idle_sel = tie_sel;
        end else if (lsu_req_i) begin
            idle_sel = ARB_SRC_LSU;
        end
    end

    // ------------------------------------------------------------------
    // Selection and forwarding
    // ------------------------------------------------------------------
    assign held      = (state_q != ARB_IDLE);
    assign sel       = held ? ((state_q == ARB_HOLD_LSU) ? ARB_SRC_LSU : ARB_SRC_VRF)
                            : idle_sel;
    assign sel_valid = held || vrf_req_i || lsu_req_i;

    // A response in this cycle pops the FIFO, so a full FIFO may still issue.
    assign slot_free  = !fifo_full || data_rvalid_i;
    assign data_req_o = rst_ni && sel_valid && slot_free;
    assign grant      = data_req_o && data_gnt_i;

    // While held, the command captured at first presentation is replayed, so
    // the memory sees a stable request even if the requester withdraws it.
    always_comb begin
        data_we_o    = vrf_we_i;
        data_be_o    = vrf_be_i;
        data_addr_o  = vrf_addr_i;
        data_wdata_o = vrf_wdata_i;
        if (held) begin
            data_we_o    = hold_we_q;
            data_be_o    = hold_be_q;
            data_addr_o  = hold_addr_q;
            data_wdata_o = hold_wdata_q;
        end else if (sel == ARB_SRC_LSU) begin
            data_we_o    = lsu_we_i;
            data_be_o    = lsu_be_i;
            data_addr_o  = lsu_addr_i;
            data_wdata_o = lsu_wdata_i;
        end
    end

    assign vrf_gnt_o = grant && (sel == ARB_SRC_VRF);
    assign lsu_gnt_o = grant && (sel == ARB_SRC_LSU);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ARB_IDLE;
        if (!grant && sel_valid) begin
            state_d = arb_hold_state(sel);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else if (!held && sel_valid && !grant) begin
            hold_we_q    <= data_we_o;
            hold_be_q    <= data_be_o;
            hold_addr_q  <= data_addr_o;
            hold_wdata_q <= data_wdata_o;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign pop = rst_ni && data_rvalid_i && !fifo_empty;

    vcve2_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (grant),
        .push_src_i (sel),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    assign vrf_rvalid_o = pop && (fifo_head == ARB_SRC_VRF);
    assign lsu_rvalid_o = pop && (fifo_head == ARB_SRC_LSU);
    assign vrf_err_o    = vrf_rvalid_o && data_err_i;
    assign lsu_err_o    = lsu_rvalid_o && data_err_i;
    assign vrf_rdata_o  = data_rdata_i;
    assign lsu_rdata_o  = data_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spurious_rvalid_o <= 1'b0;
        end else if (data_rvalid_i && fifo_empty) begin
            spurious_rvalid_o <= 1'b1;
        end
    end

    assign busy_o = !fifo_empty || sel_valid;

endmodule

// File: tb/tb_vcve2_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vcve2_dmem_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (held source, queue of in-flight owners, sticky flag)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_vcve2_dmem_arbiter;

    localparam int MAXO = 2;
    localparam int AW   = 32;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic          vrf_req, vrf_we, vrf_gnt, vrf_rvalid, vrf_err;
    logic [3:0]    vrf_be;
    logic [AW-1:0] vrf_addr;
    logic [31:0]   vrf_wdata, vrf_rdata;
    logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [3:0]    lsu_be;
    logic [AW-1:0] lsu_addr;
    logic [31:0]   lsu_wdata, lsu_rdata;
    logic          data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]    data_be;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata, data_rdata;
    logic          busy, spurious;

    vcve2_dmem_arbiter #(
        .MaxOutstanding (MAXO),
        .AddrWidth      (AW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .vrf_req_i         (vrf_req),
        .vrf_we_i          (vrf_we),
        .vrf_be_i          (vrf_be),
        .vrf_addr_i        (vrf_addr),
        .vrf_wdata_i       (vrf_wdata),
        .vrf_gnt_o         (vrf_gnt),
        .vrf_rvalid_o      (vrf_rvalid),
        .vrf_rdata_o       (vrf_rdata),
        .vrf_err_o         (vrf_err),
        .lsu_req_i         (lsu_req),
        .lsu_we_i          (lsu_we),
        .lsu_be_i          (lsu_be),
        .lsu_addr_i        (lsu_addr),
        .lsu_wdata_i       (lsu_wdata),
        .lsu_gnt_o         (lsu_gnt),
        .lsu_rvalid_o      (lsu_rvalid),
        .lsu_rdata_o       (lsu_rdata),
        .lsu_err_o         (lsu_err),
        .data_req_o        (data_req),
        .data_we_o         (data_we),
        .data_be_o         (data_be),
        .data_addr_o       (data_addr),
        .data_wdata_o      (data_wdata),
        .data_gnt_i        (data_gnt),
        .data_rvalid_i     (data_rvalid),
        .data_err_i        (data_err),
        .data_rdata_i      (data_rdata),
        .busy_o            (busy),
        .spurious_rvalid_o (spurious)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int          m_held;      // -1 none, 0 vrf, 1 lsu
    logic        m_hwe;
    logic [3:0]  m_hbe;
    logic [31:0] m_haddr;
    logic [31:0] m_hwdata;
    int          m_ids[$];
    bit          m_spur;
    int          m_prio;      // source winning the next tie (round-robin build)

    task automatic model_reset();
        m_held = -1;
        m_ids.delete();
        m_spur = 1'b0;
        m_prio = 0;
    endtask

    task automatic drive(input logic vr, input logic [31:0] va, input logic lr,
                         input logic [31:0] la, input logic g, input logic rv,
                         input logic er, input logic [31:0] rd);
        vrf_req     = vr;
        vrf_addr    = va;
        vrf_we      = 1'($urandom);
        vrf_be      = 4'($urandom);
        vrf_wdata   = $urandom;
        lsu_req     = lr;
        lsu_addr    = la;
        lsu_we      = 1'($urandom);
        lsu_be      = 4'($urandom);
        lsu_wdata   = $urandom;
        data_gnt    = g;
        data_rvalid = rv;
        data_err    = er;
        data_rdata  = rd;
    endtask

    // Predict and compare at the falling edge, then advance the model at the
    // rising edge. Inputs are expected to be set just after a rising edge.
    task automatic tick();
        int          sel, head, tie;
        bit          valid, full, ereq, egnt, pop;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ew;
        @(negedge clk);
`ifdef VCVE2_ARB_RR_EN
        tie = m_prio;
`else
        tie = 0;
`endif
        if (m_held >= 0) begin
            valid = 1'b1;
            sel = m_held;
            ewe = m_hwe; ebe = m_hbe; ea = m_haddr; ew = m_hwdata;
        end else begin
            valid = vrf_req || lsu_req;
            sel = (vrf_req && lsu_req) ? tie : (lsu_req ? 1 : 0);
            if (sel == 0) begin ewe = vrf_we; ebe = vrf_be; ea = vrf_addr; ew = vrf_wdata; end
            else          begin ewe = lsu_we; ebe = lsu_be; ea = lsu_addr; ew = lsu_wdata; end
        end
        full = (m_ids.size() == MAXO);
        ereq = valid && (!full || data_rvalid);
        egnt = ereq && data_gnt;
        pop  = data_rvalid && (m_ids.size() > 0);
        head = pop ? m_ids[0] : -1;

        check("data_req", data_req, ereq);
        if (ereq) begin
            check("data_addr", data_addr, ea);
            check("data_we", data_we, ewe);
            check("data_be", data_be, ebe);
            check("data_wdata", data_wdata, ew);
        end
        check("vrf_gnt", vrf_gnt, egnt && sel == 0);
        check("lsu_gnt", lsu_gnt, egnt && sel == 1);
        check("vrf_rvalid", vrf_rvalid, head == 0);
        check("lsu_rvalid", lsu_rvalid, head == 1);
        check("vrf_err", vrf_err, head == 0 && data_err);
        check("lsu_err", lsu_err, head == 1 && data_err);
        check("vrf_rdata", vrf_rdata, data_rdata);
        check("lsu_rdata", lsu_rdata, data_rdata);
        check("busy", busy, (m_ids.size() != 0) || valid);
        check("spurious", spurious, m_spur);

        @(posedge clk);
        if (data_rvalid && m_ids.size() == 0) m_spur = 1'b1;
        if (pop) void'(m_ids.pop_front());
        if (egnt) begin
            m_ids.push_back(sel);
            m_held = -1;
            m_prio = 1 - sel;
        end else if (valid && m_held < 0) begin
            m_held = sel;
            m_hwe = ewe; m_hbe = ebe; m_haddr = ea; m_hwdata = ew;
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_src;
        bit vr, lr, g, rv;
        model_reset();

        // ---- reset: outputs quiet even with live inputs ----
        drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'hDEAD);
        #12;
        check("rst_data_req", data_req, 1'b0);
        check("rst_vrf_gnt", vrf_gnt, 1'b0);
        check("rst_lsu_gnt", lsu_gnt, 1'b0);
        check("rst_vrf_rvalid", vrf_rvalid, 1'b0);
        check("rst_lsu_rvalid", lsu_rvalid, 1'b0);
        check("rst_spurious", spurious, 1'b0);
        idle();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // ---- single VRF read ----
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        check("s1_vrf_gnt", vrf_gnt, 1'b1);
        check("s1_lsu_gnt", lsu_gnt, 1'b0);
        check("s1_addr", data_addr, 32'h10);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        #2;
        check("s1_vrf_rvalid", vrf_rvalid, 1'b1);
        check("s1_vrf_rdata", vrf_rdata, 32'hA5A5A5A5);
        check("s1_lsu_rvalid", lsu_rvalid, 1'b0);
        check("s1_lsu_err", lsu_err, 1'b0);
        tick();

        // ---- contention with grant withheld for three cycles ----
`ifdef VCVE2_ARB_RR_EN
        exp_src = 1;
`else
        exp_src = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100, 1'b1, 32'h200, i == 3, 1'b0, 1'b0, 32'h0);
            #2;
            check("s2_addr", data_addr, (exp_src == 1) ? 32'h200 : 32'h100);
            check("s2_vrf_gnt", vrf_gnt, (i == 3) && exp_src == 0);
            check("s2_lsu_gnt", lsu_gnt, (i == 3) && exp_src == 1);
            tick();
        end
        drive(exp_src == 1, 32'h100, exp_src == 0, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
            tick();
        end

        // ---- outstanding limit ----
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        check("s3_blocked_req", data_req, 1'b0);
        check("s3_blocked_gnt", vrf_gnt, 1'b0);
        tick();
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h1);
        #2;
        check("s3_free_req", data_req, 1'b1);
        check("s3_free_gnt", vrf_gnt, 1'b1);
        check("s3_free_rvalid", vrf_rvalid, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
            tick();
        end

        // ---- interleaved sources, error on the second response ----
        drive(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h404, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h11);
        #2;
        check("s4_r1_vrf", vrf_rvalid, 1'b1);
        check("s4_r1_lsu", lsu_rvalid, 1'b0);
        check("s4_r1_err", vrf_err, 1'b0);
        check("s4_gnt3", vrf_gnt, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h22);
        #2;
        check("s4_r2_lsu", lsu_rvalid, 1'b1);
        check("s4_r2_vrf", vrf_rvalid, 1'b0);
        check("s4_r2_lsu_err", lsu_err, 1'b1);
        check("s4_r2_vrf_err", vrf_err, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h33);
        #2;
        check("s4_r3_vrf", vrf_rvalid, 1'b1);
        check("s4_r3_lsu_err", lsu_err, 1'b0);
        tick();

        // ---- spurious response, withdrawn request, reset mid-hold ----
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h44);
        #2;
        check("s5_vrf_rvalid", vrf_rvalid, 1'b0);
        check("s5_lsu_rvalid", lsu_rvalid, 1'b0);
        tick();
        idle();
        #2;
        check("s5_spur_set", spurious, 1'b1);
        tick();
        check("s5_spur_held", spurious, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        #2;
        check("s5_hold_req", data_req, 1'b1);
        check("s5_hold_addr", data_addr, 32'h600);
        rst_ni = 1'b0;
        #1;
        check("s5_rst_req", data_req, 1'b0);
        check("s5_rst_spur", spurious, 1'b0);
        check("s5_rst_gnt", lsu_gnt, 1'b0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        idle();
        #2;
        check("s5_busy", busy, 1'b0);
        check("s5_idle_req", data_req, 1'b0);
        tick();

        // ---- randomized traffic ----
        for (int n = 0; n < 3000; n++) begin
            vr = ($urandom_range(0, 99) < 50);
            lr = ($urandom_range(0, 99) < 50);
            g  = ($urandom_range(0, 99) < 55);
            rv = (m_ids.size() > 0) ? ($urandom_range(0, 99) < 40)
                                    : ($urandom_range(0, 99) < 3);
            drive(vr, {$urandom_range(0, 255), 2'b00}, lr, {$urandom_range(0, 255), 2'b00},
                  g, rv, ($urandom_range(0, 99) < 20), $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
